if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised elastic IF/ID pipeline register: a 2-entry (main + skid) buffer carrying fetch PC and instruction from the fetch stage to decode, using a valid/ready handshake on both sides. It replaces a plain stall-enable register with full-throughput back-pressure, a synchronous flush that injects a configurable bubble instruction, and ordered, lossless transfer. It sits between the instruction-memory read port and the decode/hazard unit.

## Interface
- ADDR_W, 64, PC width in bits
- INST_W, 32, instruction width in bits
- NOP_INST, 32'h0000_0013, value driven on out_inst after reset or flush (RV `addi x0,x0,0`)
- CNT_W, 32, width of the performance counters
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous flush (branch mispredict / trap)
- in_valid  in  1  fetch presents a valid PC/instruction pair
- in_ready  out  1  buffer can accept; in transfer = in_valid && in_ready
- in_pc  in  ADDR_W  fetch PC
- in_inst  in  INST_W  fetched instruction
- out_valid  out  1  decode entry valid
- out_ready  in  1  decode accepts; out transfer = out_valid && out_ready
- out_pc  out  ADDR_W  PC to decode
- out_inst  out  INST_W  instruction to decode
- stall_cnt  out  CNT_W  back-pressure cycle count (see Configuration)
- flush_cnt  out  CNT_W  count of flushes that discarded valid entries

## Operation
- Two entries: M (drives out_*) and S (skid). out_valid = M.valid; in_ready = !S.valid && !reset.
- Reset (async): M.valid=S.valid=0, out_pc=0, out_inst=NOP_INST, S data=0, counters=0; in_ready=1 once reset deasserts.
- Priority per cycle: reset > flush > normal.
- Flush: M.valid,S.valid<=0; out_pc<=0; out_inst<=NOP_INST. Any in transfer in the flush cycle is discarded. Any out transfer in the flush cycle is a completed hand-off (decode owns squashing it).
- Normal, M free (M.valid==0 or out transfer this cycle):
  - S.valid: M<=S, S.valid<=0; an in transfer this cycle is impossible (in_ready=0).
  - else in transfer: M<=in, M.valid<=1.
  - else M.valid<=0, out_pc/out_inst hold last value.
- Normal, M held (M.valid && !out_ready): in transfer writes S, S.valid<=1; M unchanged.
- Order strictly FIFO; no entry dropped or duplicated except by flush.
- out_pc/out_inst never change while out_valid && !out_ready.

## Timing
- Latency: in transfer at cycle N -> out_valid with that data at N+1 (M free path).
- Throughput: one transfer per cycle sustained with out_ready=1.
- in_ready is a registered function (S.valid only); no combinational path out_ready -> in_ready.
- in_ready drops the cycle after S fills; rises the cycle after S drains into M.
- After flush at N: out_valid=0, in_ready=1 at N+1; first new entry visible at N+2.
- Reset asserted mid-transfer: state clears immediately, no transfer completes.

## Configuration
- IF_ID_PERF_CNT_EN defined: stall_cnt increments each cycle out_valid && !out_ready && !flush; flush_cnt increments each flush cycle with M.valid||S.valid; both saturate at 2^CNT_W-1; cleared only by reset.
- Undefined: counter logic not built; stall_cnt and flush_cnt tied to 0.

## Test plan
- Reset: assert reset mid-clock -> immediately out_valid=0, out_inst=32'h13, out_pc=0, in_ready=0; after release in_ready=1.
- Streaming: in_valid=1, out_ready=1, PCs 0x0,0x4,0x8,0xC -> out_pc 0x0,0x4,0x8,0xC on consecutive cycles one cycle later, no bubbles.
- Back-pressure: out_ready=0 while sending 0x100,0x104 -> M=0x100, S=0x104, in_ready=0; out_ready=1 -> 0x100 then 0x104 in order, in_ready=1 again; with IF_ID_PERF_CNT_EN stall_cnt equals stalled cycles.
- Flush with S full: M=0x200, S=0x204, flush=1 -> next cycle out_valid=0, out_inst=32'h13, in_ready=1; 0x300 sent -> out_pc=0x300 two cycles after flush; flush_cnt=1 (0 without macro).
- Flush with simultaneous in transfer of 0x400 -> 0x400 never appears on out_pc.
- Parameter sweep ADDR_W=32, INST_W=16, NOP_INST=16'h0001 -> streaming and flush checks pass with narrowed widths.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// ============================================================================
// Module   : if_id_skid_reg
// Purpose  : Elastic IF/ID pipeline register with a main and a skid entry,
//            valid/ready handshake on both sides, and a flush that injects a
//            bubble instruction. Optional perf counters: IF_ID_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_skid_reg #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013,
  parameter int                CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_m_valid;
  logic [ADDR_W-1:0] r_m_pc;
  logic [INST_W-1:0] r_m_inst;
  logic              r_s_valid;
  logic [ADDR_W-1:0] r_s_pc;
  logic [INST_W-1:0] r_s_inst;

  logic w_in_xfer;
  logic w_m_free;

  // in_ready depends only on registered skid state, never on out_ready.
  assign in_ready  = !r_s_valid && !reset;
  assign w_in_xfer = in_valid && in_ready;
  assign w_m_free  = !r_m_valid || out_ready;

  assign out_valid = r_m_valid;
  assign out_pc    = r_m_pc;
  assign out_inst  = r_m_inst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_pc    <= '0;
      r_m_inst  <= NOP_INST;
      r_s_valid <= 1'b0;
      r_s_pc    <= '0;
      r_s_inst  <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_pc    <= '0;
      r_m_inst  <= NOP_INST;
    end else if (w_m_free) begin
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_pc    <= r_s_pc;
        r_m_inst  <= r_s_inst;
        r_s_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_m_valid <= 1'b1;
        r_m_pc    <= in_pc;
        r_m_inst  <= in_inst;
      end else begin
        // Data holds its last value; only the valid bit drops.
        r_m_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_s_valid <= 1'b1;
      r_s_pc    <= in_pc;
      r_s_inst  <= in_inst;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;

  assign w_stall_inc = r_m_valid && !out_ready && !flush;
  assign w_flush_inc = flush && (r_m_valid || r_s_valid);

  // Both counters saturate at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_one;
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_one;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
// ============================================================================
// Module   : tb_if_id_skid_reg
// Purpose  : Directed self-checking bench for if_id_skid_reg, default widths
//            plus a narrowed instance (ADDR_W=32, INST_W=16, NOP=16'h0001).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_skid_reg;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;

  logic        in_ready, out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] stall_cnt, flush_cnt;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc;
  logic [15:0] n_out_inst;
  logic [31:0] n_stall_cnt, n_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_id_skid_reg dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_skid_reg #(.ADDR_W(32), .INST_W(16), .NOP_INST(16'h0001), .CNT_W(32)) dut_n (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_pc(in_pc[31:0]), .in_inst(in_inst[15:0]),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc), .out_inst(n_out_inst),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {16'hBEEF, pc[15:0] ^ 16'h5A5A};
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
  endtask

  initial begin
    // Reset asserted asynchronously before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 32'h13);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_n_out_inst", n_out_inst, 16'h0001);
    cyc();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_stall_cnt", stall_cnt, 0);
    chk("rel_flush_cnt", flush_cnt, 0);

    // Streaming: one entry per cycle, one cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(i * 4));
      cyc();
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 64'(i * 4));
      chk("stream_inst", out_inst, inst_of(64'(i * 4)));
      chk("stream_in_ready", in_ready, 1);
      chk("stream_n_pc", n_out_pc, 32'(i * 4));
      chk("stream_n_inst", n_out_inst, inst_of(64'(i * 4)) & 32'hFFFF);
    end
    drive(1'b0, 64'h0);
    cyc();
    chk("drain_valid", out_valid, 0);
    chk("drain_pc_hold", out_pc, 64'hC);

    // Back-pressure: fill M then S, then release.
    out_ready = 1'b0;
    drive(1'b1, 64'h100);
    cyc();
    chk("bp_m_pc", out_pc, 64'h100);
    chk("bp_in_ready1", in_ready, 1);
    drive(1'b1, 64'h104);
    cyc();
    chk("bp_hold_pc", out_pc, 64'h100);
    chk("bp_in_ready0", in_ready, 0);
    drive(1'b1, 64'h108);
    cyc();
    chk("bp_hold_pc2", out_pc, 64'h100);
    chk("bp_hold_inst", out_inst, inst_of(64'h100));
    chk("bp_in_ready0b", in_ready, 0);
    drive(1'b0, 64'h0);
    out_ready = 1'b1;
    cyc();
    chk("bp_rel_pc", out_pc, 64'h104);
    chk("bp_rel_valid", out_valid, 1);
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_stall_cnt", stall_cnt, PERF ? 2 : 0);
    cyc();
    chk("bp_empty", out_valid, 0);

    // Flush with both entries full.
    out_ready = 1'b0;
    drive(1'b1, 64'h200);
    cyc();
    drive(1'b1, 64'h204);
    cyc();
    chk("fl_s_full", in_ready, 0);
    drive(1'b0, 64'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_inst", out_inst, 32'h13);
    chk("fl_pc", out_pc, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_n_inst", n_out_inst, 16'h0001);
    chk("fl_flush_cnt", flush_cnt, PERF ? 1 : 0);
    out_ready = 1'b1;
    drive(1'b1, 64'h300);
    cyc();
    chk("fl_new_pc", out_pc, 64'h300);
    chk("fl_new_valid", out_valid, 1);
    chk("fl_n_new_pc", n_out_pc, 32'h300);
    chk("fl_stall_cnt", stall_cnt, PERF ? 3 : 0);

    // Flush coincident with an accepted input: 0x400 must be discarded.
    drive(1'b1, 64'h400);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 64'h0);
    chk("fl2_valid", out_valid, 0);
    chk("fl2_pc", out_pc, 0);
    chk("fl2_flush_cnt", flush_cnt, PERF ? 2 : 0);
    cyc();
    chk("fl2_valid_b", out_valid, 0);
    chk("fl2_pc_b", out_pc, 0);
    drive(1'b1, 64'h500);
    cyc();
    drive(1'b0, 64'h0);
    chk("fl2_next_pc", out_pc, 64'h500);

    // Reset asserted mid-cycle clears state immediately.
    out_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_inst", out_inst, 32'h13);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_flush", flush_cnt, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
